button_step_ctrl: RTL and testbench

- Front-end controller for push-button inputs driving counter-enable (`cnt_en`) style logic on CLOCK_50.
- Synchronizes and debounces a raw key, then sequences single-cycle command pulses: press, auto-repeat while held, and release.
- Sits between the board key pins and the counter/FSM enables; replaces bare edge pulsing wherever a key must step a value.

---
 rtl/button_pkg.sv | 16 +
 rtl/debounce_filter.sv | 52 +++++
 rtl/button_step_ctrl.sv | 116 +++++++++++
 tb/tb_button_step_ctrl.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared definitions for the push-button step controller.
//   state_t    : controller FSM encoding
//   cnt_width  : counter width for a terminal count of n (at least 1 bit)
package button_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    HOLD_WAIT = 2'd1,
    REPEAT    = 2'd2
  } state_t;

  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/debounce_filter.sv
// Synchronizes a raw key input and accepts a level change only after it has
// been stable for DEBOUNCE_CYCLES consecutive clocks.
//   i_clk     : system clock
//   i_rst     : asynchronous reset, active-high
//   i_btn_raw : raw asynchronous key
//   o_level   : filtered level (1 = pressed), changes one clock ahead of the
//               registered btn_level in the top so the FSM can pulse with it
module debounce_filter
  import button_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_raw,
  output logic o_level
);

  localparam int unsigned   DW      = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DW-1:0]          r_cnt;
  logic                   r_level;
  logic                   w_in;
  logic                   w_s_sync;

  assign w_in     = ACTIVE_LOW ? ~i_btn_raw : i_btn_raw;
  assign w_s_sync = r_sync[SYNC_STAGES-1];
  assign o_level  = r_level;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_in};
      if (w_s_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == DB_LAST) begin
        r_level <= ~r_level;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + DW'(1);
      end
    end
  end

endmodule

// File: rtl/button_step_ctrl.sv
// Push-button front end: debounces a key and issues one-cycle press,
// auto-repeat and release pulses; step = press | repeat drives cnt_en.
//   clk, rst        : system clock, asynchronous active-high reset
//   btn_raw         : raw key input
//   repeat_en       : auto-repeat enable (timer freezes while low)
//   btn_level       : debounced pressed level
//   press_pulse     : one cycle on accepted press
//   repeat_pulse    : one cycle per auto-repeat tick
//   release_pulse   : one cycle on accepted release
//   step            : press_pulse | repeat_pulse
//
// state     | meaning
// IDLE      | key released, waiting for accepted press
// HOLD_WAIT | pressed, counting HOLD_CYCLES to first repeat
// REPEAT    | pressed, repeating every REPEAT_CYCLES
module button_step_ctrl
  import button_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned HOLD_CYCLES     = 25000000,
  parameter int unsigned REPEAT_CYCLES   = 5000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  input  logic repeat_en,
  output logic btn_level,
  output logic press_pulse,
  output logic repeat_pulse,
  output logic release_pulse,
  output logic step
);

  localparam int unsigned   MAX_CYC  = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int unsigned   TW       = cnt_width(MAX_CYC);
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

  logic          w_filt;
  logic [TW-1:0] w_last;
  state_t        r_state;
  logic [TW-1:0] r_timer;
  logic          r_btn_level;
  logic          r_press;
  logic          r_repeat;
  logic          r_release;

  debounce_filter #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .ACTIVE_LOW     (ACTIVE_LOW)
  ) u_debounce (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_btn_raw(btn_raw),
    .o_level  (w_filt)
  );

  assign w_last = (r_state == REPEAT) ? REP_LAST : HOLD_LAST;

  // btn_level is registered alongside the pulses so a pulse and the level
  // change it announces appear in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_timer     <= '0;
      r_btn_level <= 1'b0;
      r_press     <= 1'b0;
      r_repeat    <= 1'b0;
      r_release   <= 1'b0;
    end else begin
      r_btn_level <= w_filt;
      r_press     <= 1'b0;
      r_repeat    <= 1'b0;
      r_release   <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_filt) begin
            r_press <= 1'b1;
            r_timer <= '0;
            r_state <= HOLD_WAIT;
          end
        end
        HOLD_WAIT, REPEAT: begin
          // release wins over a repeat falling due in the same cycle
          if (!w_filt) begin
            r_release <= 1'b1;
            r_timer   <= '0;
            r_state   <= IDLE;
          end else if (repeat_en) begin
            if (r_timer == w_last) begin
              r_repeat <= 1'b1;
              r_timer  <= '0;
              r_state  <= REPEAT;
            end else begin
              r_timer <= r_timer + TW'(1);
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign btn_level     = r_btn_level;
  assign press_pulse   = r_press;
  assign repeat_pulse  = r_repeat;
  assign release_pulse = r_release;
  assign step          = r_press | r_repeat;

endmodule

// File: tb/tb_button_step_ctrl.sv
// Directed bench for button_step_ctrl with small timing parameters.
// Time index t = k means edge k; edge 0 is the first edge sampling the new
// raw value. Inputs are changed 1 unit after an edge, outputs are read there.
module tb_button_step_ctrl;

  logic clk = 1'b0;
  logic rst;
  logic btn_raw, repeat_en;
  logic btn_level, press_pulse, repeat_pulse, release_pulse, step;
  logic btn_raw_al;
  logic al_level, al_press, al_repeat, al_release, al_step;

  int n_vec = 0;
  int n_err = 0;
  int t     = 0;

  always #5 clk = ~clk;

  button_step_ctrl #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10),
    .REPEAT_CYCLES(4), .ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .btn_raw(btn_raw), .repeat_en(repeat_en),
    .btn_level(btn_level), .press_pulse(press_pulse),
    .repeat_pulse(repeat_pulse), .release_pulse(release_pulse), .step(step)
  );

  button_step_ctrl #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .HOLD_CYCLES(10),
    .REPEAT_CYCLES(4), .ACTIVE_LOW(1'b1)
  ) dut_al (
    .clk(clk), .rst(rst), .btn_raw(btn_raw_al), .repeat_en(1'b1),
    .btn_level(al_level), .press_pulse(al_press),
    .repeat_pulse(al_repeat), .release_pulse(al_release), .step(al_step)
  );

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0d got{lvl,prs,rep,rel,stp}=%b exp=%b", tag, t, got, exp);
    end
  endtask

  function automatic logic [4:0] obs();
    return {btn_level, press_pulse, repeat_pulse, release_pulse, step};
  endfunction

  function automatic logic [4:0] obs_al();
    return {al_level, al_press, al_repeat, al_release, al_step};
  endfunction

  // repeat_en low for edges en_off+1 .. en_on
  function automatic logic en_at(input int j, input int en_off, input int en_on);
    return !((j > en_off) && (j <= en_on));
  endfunction

  // Key held for edges 0..hold_end; expected press at p_t, release at rel_t,
  // repeats every 4 clocks from rep_first to rep_last (rep_first < 0: none).
  task automatic run_seg(input string tag, input int k_start, input int k_end,
                         input int hold_end, input int p_t, input int rel_t,
                         input int rep_first, input int rep_last,
                         input int en_off, input int en_on);
    logic e_lvl, e_prs, e_rep, e_rel;
    btn_raw   = (k_start <= hold_end);
    repeat_en = en_at(k_start, en_off, en_on);
    for (int k = k_start; k <= k_end; k++) begin
      @(posedge clk);
      #1;
      t     = k;
      e_lvl = (k >= p_t) && (k < rel_t);
      e_prs = (k == p_t);
      e_rel = (k == rel_t);
      e_rep = (rep_first >= 0) && (k >= rep_first) && (k <= rep_last) &&
              (((k - rep_first) % 4) == 0);
      chk(tag, obs(), {e_lvl, e_prs, e_rep, e_rel, e_prs | e_rep});
      btn_raw   = (k + 1 <= hold_end);
      repeat_en = en_at(k + 1, en_off, en_on);
    end
  endtask

  task automatic idle(input int n);
    btn_raw   = 1'b0;
    repeat_en = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst        = 1'b1;
    btn_raw    = 1'b0;
    repeat_en  = 1'b1;
    btn_raw_al = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", obs(), 5'b0);
    chk("reset_state_al", obs_al(), 5'b0);
    rst = 1'b0;

    // Active-low instance idles with btn_raw=1: nothing may happen
    for (int k = 0; k < 12; k++) begin
      @(posedge clk);
      #1;
      t = k;
      chk("al_idle", obs_al(), 5'b0);
    end

    // Clean press held 30 clocks
    run_seg("clean", 0, 44, 29, 6, 36, 16, 32, -1, -1);
    idle(10);

    // Bounce: 3 high, 1 low, 3 high, then low
    for (int k = 0; k < 20; k++) begin
      btn_raw = (k <= 2) || (k >= 4 && k <= 6);
      @(posedge clk);
      #1;
      t = k;
      chk("bounce", obs(), 5'b0);
    end
    idle(10);

    // repeat_en low throughout a 40-clock hold
    run_seg("no_repeat", 0, 54, 39, 6, 46, -1, -1, -1, 1000);
    idle(10);

    // repeat_en dropped after edge 12, raised after edge 20
    run_seg("en_gap", 0, 54, 39, 6, 46, 24, 44, 12, 20);
    idle(10);

    // Release lands on the cycle a repeat would fire
    run_seg("rel_prio", 0, 40, 25, 6, 32, 16, 28, -1, -1);
    idle(10);

    // Reset mid-press with key still held
    run_seg("pre_rst", 0, 18, 1000, 6, 1000, 16, 16, -1, -1);
    rst = 1'b1;
    #1;
    chk("rst_async", obs(), 5'b0);
    @(posedge clk);
    #1;
    t = 19;
    chk("rst_hold", obs(), 5'b0);
    rst = 1'b0;
    run_seg("post_rst", 20, 52, 40, 26, 47, 36, 44, -1, -1);
    idle(10);

    // Active-low instance: press by driving btn_raw low
    btn_raw_al = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      t = k;
      chk("al_press", obs_al(), {(k >= 6), (k == 6), 1'b0, 1'b0, (k == 6)});
    end
    btn_raw_al = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
